// File: rtl/icache_responder_pkg.sv
// Shared types for the instruction cache: address split, FSM states and sizing.
package icache_types_pkg;

    localparam int unsigned ICACHE_SETS = 16;
    localparam int unsigned ICACHE_IDXW = $clog2(ICACHE_SETS);
    localparam int unsigned ICACHE_TAGW = 30 - ICACHE_IDXW;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [ICACHE_TAGW-1:0] tag;
        logic [ICACHE_IDXW-1:0] idx;
        logic [1:0]             bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE,
        FETCH
    } icache_state_t;

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side signals of the instruction cache, plus its counters.
interface icache_responder_if;
    import icache_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  flush;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;
    word_t hit_count;
    word_t miss_count;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

endinterface

// File: rtl/icache_frame_array.sv
// Direct-mapped valid/tag/data storage: one combinational read port, one
// synchronous write port, and a synchronous clear-all that beats the write.
module icache_frame_array
    import icache_types_pkg::*;
#(
    parameter int unsigned SETS = ICACHE_SETS,
    parameter int unsigned TAGW = 30 - $clog2(SETS)
) (
    input  logic                    CLK,
    input  logic                    i_clr,
    input  logic [$clog2(SETS)-1:0] i_rd_idx,
    output logic                    o_rd_valid,
    output logic [TAGW-1:0]         o_rd_tag,
    output word_t                   o_rd_data,
    input  logic                    i_wr_en,
    input  logic [$clog2(SETS)-1:0] i_wr_idx,
    input  logic [TAGW-1:0]         i_wr_tag,
    input  word_t                   i_wr_data
);

    logic [SETS-1:0] r_valid;
    logic [TAGW-1:0] r_tag  [SETS];
    word_t           r_data [SETS];

    // A fill landing in the same cycle as a clear must leave its frame invalid.
    always_ff @(posedge CLK) begin
        if (i_clr) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: same-cycle hits, single outstanding miss
// fetched from memory and filled before the fetch stage retries.
module icache_responder
    import icache_types_pkg::*;
#(
    parameter int unsigned SETS = ICACHE_SETS
) (
    input  logic              CLK,
    input  logic              RST,
    icache_responder_if.slave cif
);

    localparam int unsigned IDXW = $clog2(SETS);
    localparam int unsigned TAGW = 30 - IDXW;

    icache_state_t   r_state;
    icache_state_t   w_next;
    logic [29:0]     r_miss_word;
    word_t           r_hit_count;
    word_t           r_miss_count;

    logic [IDXW-1:0] w_idx;
    logic [TAGW-1:0] w_tag;
    logic [IDXW-1:0] w_fill_idx;
    logic [TAGW-1:0] w_fill_tag;
    logic            w_rd_valid;
    logic [TAGW-1:0] w_rd_tag;
    word_t           w_rd_data;
    logic            w_hit;
    logic            w_miss;
    logic            w_fill;

    assign w_tag      = cif.imemaddr[31:2+IDXW];
    assign w_idx      = cif.imemaddr[1+IDXW:2];
    assign w_fill_tag = r_miss_word[29:IDXW];
    assign w_fill_idx = r_miss_word[IDXW-1:0];

    icache_frame_array #(
        .SETS (SETS),
        .TAGW (TAGW)
    ) u_frames (
        .CLK        (CLK),
        .i_clr      (RST | cif.flush),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_fill),
        .i_wr_idx   (w_fill_idx),
        .i_wr_tag   (w_fill_tag),
        .i_wr_data  (cif.iload)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // All outputs are forced quiet while RST is held, even mid-fetch.
    always_comb begin
        w_next       = r_state;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        w_fill       = 1'b0;
        cif.ihit     = 1'b0;
        cif.imemload = '0;
        cif.iREN     = 1'b0;
        cif.iaddr    = '0;
        if (!RST) begin
            case (r_state)
                IDLE: begin
                    w_hit    = cif.imemREN & w_rd_valid & (w_rd_tag == w_tag);
                    w_miss   = cif.imemREN & ~w_hit & ~cif.flush;
                    cif.ihit = w_hit;
                    if (w_hit) begin
                        cif.imemload = w_rd_data;
                    end
                    if (w_miss) begin
                        w_next = FETCH;
                    end
                end
                FETCH: begin
                    cif.iREN  = 1'b1;
                    cif.iaddr = {r_miss_word, 2'b00};
                    if (!cif.iwait) begin
                        w_fill = 1'b1;
                        w_next = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_miss_word <= '0;
        end else if (w_miss) begin
            r_miss_word <= cif.imemaddr[31:2];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign cif.hit_count  = r_hit_count;
    assign cif.miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_responder.sv
// Table-driven bench for icache_responder with a scoreboard of expected
// per-cycle results, plus a variable-latency miss sequence.
module tb_icache_responder;
    import icache_types_pkg::*;

    typedef struct {
        logic        rst;
        logic        ren;
        logic [31:0] addr;
        logic        fl;
        logic        iw;
        logic [31:0] ld;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_iren;
        logic [31:0] e_iaddr;
        logic [31:0] e_hc;
        logic [31:0] e_mc;
    } vec_t;

    logic CLK;
    logic RST;
    int unsigned checks;
    int unsigned errors;

    vec_t        tbl[$];
    vec_t        exp_q[$];
    logic [31:0] data_q[$];

    icache_responder_if cif ();

    icache_responder #(
        .SETS (16)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .cif (cif)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog addr=%h got timeout want finish", cif.imemaddr);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d addr=%h got %h want %h", nm, idx, cif.imemaddr, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic ren, input logic [31:0] addr,
                                input logic fl, input logic iw, input logic [31:0] ld,
                                input logic eh, input logic [31:0] el, input logic er,
                                input logic [31:0] ea, input logic [31:0] ehc, input logic [31:0] emc);
        vec_t v;
        v.rst = rst; v.ren = ren; v.addr = addr; v.fl = fl; v.iw = iw; v.ld = ld;
        v.e_hit = eh; v.e_load = el; v.e_iren = er; v.e_iaddr = ea; v.e_hc = ehc; v.e_mc = emc;
        return v;
    endfunction

    initial begin
        vec_t        e;
        int unsigned n_wait;
        int unsigned seen;
        logic        done;

        checks = 0;
        errors = 0;
        RST          = 1'b1;
        cif.imemREN  = 1'b0;
        cif.imemaddr = '0;
        cif.flush    = 1'b0;
        cif.iwait    = 1'b1;
        cif.iload    = '0;

        //          rst ren addr          fl iw load           hit load           iren iaddr         hc  mc
        tbl.push_back(mk(1, 1, 32'h0000_0040, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0040, 0,  1));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0040, 0,  1));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 0, 32'hDEAD_BEEF, 0, 32'h0,         1, 32'h0000_0040, 0,  1));
        tbl.push_back(mk(0, 1, 32'h0000_0042, 0, 1, 32'h0,         1, 32'hDEAD_BEEF, 0, 32'h0,         0,  1));
        tbl.push_back(mk(0, 1, 32'h0000_0042, 0, 1, 32'h0,         1, 32'hDEAD_BEEF, 0, 32'h0,         1,  1));
        tbl.push_back(mk(0, 1, 32'h0000_0042, 0, 1, 32'h0,         1, 32'hDEAD_BEEF, 0, 32'h0,         2,  1));
        tbl.push_back(mk(0, 1, 32'h0000_0042, 0, 1, 32'h0,         1, 32'hDEAD_BEEF, 0, 32'h0,         3,  1));
        tbl.push_back(mk(0, 0, 32'h0000_0080, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0,         4,  1));
        tbl.push_back(mk(0, 1, 32'h0000_0080, 0, 0, 32'h1111_1111, 0, 32'h0,         0, 32'h0,         4,  1));
        tbl.push_back(mk(0, 1, 32'h0000_0080, 0, 0, 32'h1111_1111, 0, 32'h0,         1, 32'h0000_0080, 4,  2));
        tbl.push_back(mk(0, 1, 32'h0000_0080, 0, 1, 32'h0,         1, 32'h1111_1111, 0, 32'h0,         4,  2));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0,         5,  2));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 0, 32'hDEAD_BEEF, 0, 32'h0,         1, 32'h0000_0040, 5,  3));
        tbl.push_back(mk(0, 1, 32'h0000_0040, 0, 1, 32'h0,         1, 32'hDEAD_BEEF, 0, 32'h0,         5,  3));
        tbl.push_back(mk(0, 1, 32'h0000_0100, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0,         6,  3));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 0, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0100, 6,  4));
        tbl.push_back(mk(0, 0, 32'h0000_0200, 0, 0, 32'hAAAA_0100, 0, 32'h0,         1, 32'h0000_0100, 6,  4));
        tbl.push_back(mk(0, 1, 32'h0000_0100, 0, 1, 32'h0,         1, 32'hAAAA_0100, 0, 32'h0,         6,  4));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 0, 0, 32'hBBBB_0200, 0, 32'h0,         0, 32'h0,         7,  4));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 0, 0, 32'hBBBB_0200, 0, 32'h0,         1, 32'h0000_0200, 7,  5));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 0, 1, 32'h0,         1, 32'hBBBB_0200, 0, 32'h0,         7,  5));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 1, 1, 32'h0,         1, 32'hBBBB_0200, 0, 32'h0,         8,  5));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0,         9,  5));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 1, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0200, 9,  6));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 0, 0, 32'hCCCC_0200, 0, 32'h0,         1, 32'h0000_0200, 9,  6));
        tbl.push_back(mk(0, 1, 32'h0000_0200, 0, 1, 32'h0,         1, 32'hCCCC_0200, 0, 32'h0,         9,  6));
        tbl.push_back(mk(0, 1, 32'h0000_0300, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0,         10, 6));
        tbl.push_back(mk(0, 1, 32'h0000_0300, 1, 0, 32'hDDDD_0300, 0, 32'h0,         1, 32'h0000_0300, 10, 7));
        tbl.push_back(mk(0, 1, 32'h0000_0300, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0,         10, 7));
        tbl.push_back(mk(0, 1, 32'h0000_0300, 0, 0, 32'hEEEE_0300, 0, 32'h0,         1, 32'h0000_0300, 10, 8));
        tbl.push_back(mk(0, 1, 32'h0000_0300, 0, 1, 32'h0,         1, 32'hEEEE_0300, 0, 32'h0,         10, 8));
        tbl.push_back(mk(0, 1, 32'h0000_0044, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0,         11, 8));
        tbl.push_back(mk(0, 1, 32'h0000_0044, 0, 1, 32'h0,         0, 32'h0,         1, 32'h0000_0044, 11, 9));
        tbl.push_back(mk(1, 1, 32'h0000_0044, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0,         11, 9));
        tbl.push_back(mk(0, 1, 32'h0000_0300, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 1, 32'h0000_0300, 0, 0, 32'h1234_5678, 0, 32'h0,         1, 32'h0000_0300, 0,  1));
        tbl.push_back(mk(0, 0, 32'h0000_0300, 0, 1, 32'h0,         0, 32'h0,         0, 32'h0,         0,  1));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge CLK);
            #1;
            RST          = tbl[i].rst;
            cif.imemREN  = tbl[i].ren;
            cif.imemaddr = tbl[i].addr;
            cif.flush    = tbl[i].fl;
            cif.iwait    = tbl[i].iw;
            cif.iload    = tbl[i].ld;
            exp_q.push_back(tbl[i]);
            #1;
            e = exp_q.pop_front();
            chk("ihit",       i, 32'(cif.ihit), 32'(e.e_hit));
            chk("imemload",   i, cif.imemload,  e.e_load);
            chk("iREN",       i, 32'(cif.iREN), 32'(e.e_iren));
            chk("iaddr",      i, cif.iaddr,     e.e_iaddr);
            chk("hit_count",  i, cif.hit_count, e.e_hc);
            chk("miss_count", i, cif.miss_count, e.e_mc);
        end

        // Miss with a randomly long memory wait on a fresh index.
        n_wait = $urandom_range(1, 5);
        seen   = 0;
        done   = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(posedge CLK);
            #1;
            RST          = 1'b0;
            cif.imemREN  = 1'b1;
            cif.imemaddr = 32'h0000_008C;
            cif.flush    = 1'b0;
            cif.iwait    = (seen >= n_wait) ? 1'b0 : 1'b1;
            cif.iload    = 32'h5A5A_008C;
            #1;
            if (cif.iREN) begin
                chk("seq_iaddr", c, cif.iaddr, 32'h0000_008C);
                if (!cif.iwait) data_q.push_back(32'h5A5A_008C);
                seen++;
            end
            if (cif.ihit) begin
                if (data_q.size() == 0) begin
                    chk("seq_hit_before_fill", c, 32'(cif.ihit), 32'd0);
                end else begin
                    chk("seq_data", c, cif.imemload, data_q.pop_front());
                end
                chk("seq_fetch_cycles", c, 32'(seen), 32'(n_wait + 1));
                chk("seq_miss_count", c, cif.miss_count, 32'd2);
                chk("seq_hit_count", c, cif.hit_count, 32'd0);
                chk("seq_iren_on_hit", c, 32'(cif.iREN), 32'd0);
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL seq_timeout addr=%h got no hit want hit within 30 cycles", cif.imemaddr);
        end

        @(posedge CLK);
        #1;
        cif.imemREN = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
